// File: rtl/signed_sat_accumulator_pkg.sv
// rtl/signed_sat_accumulator_pkg.sv - shared state type and saturation limits
package signed_sat_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sat_acc_state_t;

    // Two's complement limits for a signed value of width w (w <= 63).
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/signed_sat_accumulator_if.sv
// rtl/signed_sat_accumulator_if.sv - sample in / frame total out handshake bundle
interface signed_sat_accumulator_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8
);
    logic                    up_valid;
    logic                    up_ready;
    logic signed [IN_W-1:0]  up_data;
    logic                    down_valid;
    logic                    down_ready;
    logic signed [ACC_W-1:0] down_data;
    logic                    down_sat;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_sat
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_sat
    );
endinterface

// File: rtl/signed_sat_accumulator_add.sv
// rtl/signed_sat_accumulator_add.sv - combinational signed add clamped to OUT_W
module signed_sat_add_w
    import signed_sat_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 4,
    parameter int OUT_W = 8
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [OUT_W-1:0] y,
    output logic                    overflow
);
    localparam int AB_W = (A_W > B_W) ? A_W : B_W;
    // One guard bit above the widest operand/result so the raw sum never wraps.
    localparam int W    = ((AB_W > OUT_W) ? AB_W : OUT_W) + 1;

    localparam logic signed [W-1:0] MAX_W = W'(sat_max(OUT_W));
    localparam logic signed [W-1:0] MIN_W = W'(sat_min(OUT_W));

    logic signed [W-1:0] sum;
    logic                above;
    logic                below;

    assign sum      = W'(a) + W'(b);
    assign above    = sum > MAX_W;
    assign below    = sum < MIN_W;
    assign overflow = above | below;

    assign y = above ? MAX_W[OUT_W-1:0] :
               below ? MIN_W[OUT_W-1:0] :
                       sum[OUT_W-1:0];
endmodule

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - frame accumulator with per-step saturation
module signed_sat_accumulator
    import signed_sat_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int ACC_W     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    signed_sat_accumulator_if.slave bus
);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    sat_acc_state_t          state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;

    logic signed [ACC_W-1:0] add_y;
    logic                    add_ovf;
    logic                    last;

    signed_sat_add_w #(
        .A_W   (ACC_W),
        .B_W   (IN_W),
        .OUT_W (ACC_W)
    ) u_add (
        .a        (acc_q),
        .b        (bus.up_data),
        .y        (add_y),
        .overflow (add_ovf)
    );

    assign last = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            ACCUM: begin
                if (bus.up_valid) begin
                    acc_d = add_y;
                    sat_d = sat_q | add_ovf;
                    // cnt parks on the last index; only the HOLD exit clears it.
                    if (last) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.down_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign bus.up_ready   = (state_q == ACCUM);
    assign bus.down_valid = (state_q == HOLD);
    assign bus.down_data  = acc_q;
    assign bus.down_sat   = sat_q;
endmodule

// File: doc/signed_sat_accumulator.md
# signed_sat_accumulator

Streaming stage directly downstream of the 4-bit signed saturating adder. It consumes the adder's saturated sums over a valid/ready interface. It accumulates a fixed-length frame of samples into a wider signed accumulator with per-step saturation, then presents the frame total and a sticky saturation flag to the next stage.

## Interface
- `IN_W`, 4, width of each signed input sample (two's complement)
- `ACC_W`, 8, width of the signed accumulator and result; must be >= `IN_W`
- `FRAME_LEN`, 4, samples per frame; must be >= 1
- `clk` input 1, the single clock; all state on rising edge
- `rst_n` input 1, reset, asynchronous and active-low
- `up_valid` input 1, upstream sample valid
- `up_ready` output 1, block accepts a sample this cycle
- `up_data` input `IN_W`, signed sample
- `down_valid` output 1, frame result valid
- `down_ready` input 1, downstream accepts the result
- `down_data` output `ACC_W`, signed saturated frame total
- `down_sat` output 1, at least one saturation event occurred in this frame

## Operation
- Two states: ACCUM and HOLD.
- **ACCUM**
  - `up_ready`=1 and `down_valid`=0.
  - On an upstream handshake (`up_valid` & `up_ready`):
    - acc <= sat(acc + sext(`up_data`)).
    - sat_flag |= saturation event for this step.
    - cnt increments.
  - When the accepted sample is the last of the frame (cnt == `FRAME_LEN`-1), go to HOLD.
- **HOLD**
  - `up_ready`=0 and `down_valid`=1.
  - `down_data` = acc and `down_sat` = sat_flag. Both are held stable while `down_valid`=1 and `down_ready`=0.
  - On a downstream handshake (`down_valid` & `down_ready`): acc <= 0, sat_flag <= 0, cnt <= 0, go to ACCUM.
- Arithmetic rules:
  - Compute acc + sext(`up_data`) in `ACC_W`+1 bits.
  - If the result is above 2^(`ACC_W`-1)-1, clamp to max. If it is below -2^(`ACC_W`-1), clamp to min.
  - Either clamp counts as a saturation event.
- Saturation is applied at every step, not only at the end of the frame, so sample order affects the result.
- `up_valid` low in ACCUM: no state change; gaps between samples are allowed.
- `up_data` is ignored unless a handshake occurs.
- `FRAME_LEN`=1: every accepted sample goes directly to HOLD.
- `down_ready` asserted in ACCUM is ignored.
- `up_valid` asserted in HOLD is ignored; the sample is not consumed.
- Reset asserted at any time, including mid-frame or in HOLD: immediately forces state=ACCUM and acc, cnt, sat_flag to 0. The partial frame is discarded.

## Timing
- Reset values of outputs: `up_ready`=1, `down_valid`=0, `down_data`=0, `down_sat`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `up_valid`/`down_ready` to any output.
- Latency: `down_valid` rises the cycle after the handshake of the last sample in the frame.
- Throughput: at most one frame every `FRAME_LEN`+1 cycles. The first sample of the next frame can be accepted in the cycle after the downstream handshake.
- cnt width: $clog2(`FRAME_LEN`), minimum 1 bit. cnt wraps to 0 only through the HOLD exit.

## Structure
- Package `signed_sat_pkg` contains:
  - the state typedef `sat_acc_state_t` (ACCUM, HOLD);
  - a parameterised max/min constant helper for a given width.
- Sub-module `signed_sat_add_w` (parameters `A_W`, `B_W`, `OUT_W`): combinational signed add of two operands with sign extension, clamping to `OUT_W`, and an `overflow` output. Instantiate it once for the accumulate step.
- The top module holds the state register, acc, cnt and sat_flag.

## Test plan
All cases use `IN_W`=4, `ACC_W`=5 (range -16..15) and `FRAME_LEN`=4, with `down_ready`=1 unless noted.
- Samples 3,-2,1,-1 -> `down_data`=1, `down_sat`=0, with `down_valid` high for one cycle, the cycle after the 4th handshake.
- Samples 7,7,7,7 -> partial sums 7, 14, 15 (clamped), 15 -> `down_data`=15, `down_sat`=1.
- Samples -8,-8,-8,7 -> partial sums -8, -16, -16 (clamped), -9 -> `down_data`=-9, `down_sat`=1. This checks per-step saturation.
- Samples 1,1,1,1 with `down_ready`=0 for 5 cycles -> `down_data`=4 held stable and `up_ready`=0 throughout. After release: one handshake, then `up_ready`=1 and the next frame starts from 0 with `down_sat`=0.
- Samples 5,5 accepted, then `rst_n` pulsed low mid-cycle (asynchronous) -> outputs return to reset values immediately. Samples 2,2,2,2 then give `down_data`=8, `down_sat`=0.
- Samples 1,2,3,4 delivered with random `up_valid` gaps -> `down_data`=10. `up_data` values presented while `up_valid`=0 must have no effect.
